// File: rtl/mac_operand_feeder.sv
// Operand feeder for a 4-lane MAC tile: packs a serial (a,b) stream into lane groups,
// accumulates MAC results across K groups through the c input, returns the final psum.

module mac_operand_feeder_lane #(
  parameter int bw = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [bw-1:0] in_a,
  input  logic [bw-1:0] in_b,
  output logic [bw-1:0] a,
  output logic [bw-1:0] b
);
  logic [bw-1:0] a_q, a_d, b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (we) begin
      a_d = in_a;
      b_d = in_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
endmodule

module mac_operand_feeder #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic [bw-1:0]      mac_a0,
  output logic [bw-1:0]      mac_a1,
  output logic [bw-1:0]      mac_a2,
  output logic [bw-1:0]      mac_a3,
  output logic [bw-1:0]      mac_b0,
  output logic [bw-1:0]      mac_b1,
  output logic [bw-1:0]      mac_b2,
  output logic [bw-1:0]      mac_b3,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               busy
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, FILL, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [psum_bw-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [len_bw-1:0]    cnt_q, cnt_d;
  logic [len_bw-1:0]    k_q, k_d;
  logic [len_bw-1:0]    cnt_inc;
  logic                 in_fire;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][bw-1:0]  lane_a, lane_b;

  assign in_fire = in_valid & in_ready;
  assign cnt_inc = cnt_q + len_bw'(1);

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      assign lane_we[l] = in_fire && (idx_q == IDX_W'(l));
      mac_operand_feeder_lane #(.bw(bw)) u_lane (
        .clk   (clk),
        .reset (reset),
        .we    (lane_we[l]),
        .in_a  (in_a),
        .in_b  (in_b),
        .a     (lane_a[l]),
        .b     (lane_b[l])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (len != '0)) state_d = FILL;
      FILL:    if (in_fire && (idx_q == IDX_W'(NUM_LANES-1))) state_d = ACC;
      ACC:     state_d = (cnt_inc == k_q) ? DONE : FILL;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath: job setup in IDLE, lane index in FILL, accumulate in ACC.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    k_d   = k_q;
    case (state_q)
      IDLE: if (start && (len != '0)) begin
        k_d   = len;
        acc_d = '0;
        idx_d = '0;
        cnt_d = '0;
      end
      FILL: if (in_fire) idx_d = idx_q + IDX_W'(1);
      ACC: begin
        acc_d = mac_out;
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      k_q   <= k_d;
    end
  end

  assign mac_a0   = lane_a[0];
  assign mac_a1   = lane_a[1];
  assign mac_a2   = lane_a[2];
  assign mac_a3   = lane_a[3];
  assign mac_b0   = lane_b[0];
  assign mac_b1   = lane_b[1];
  assign mac_b2   = lane_b[2];
  assign mac_b3   = lane_b[3];
  assign mac_c    = acc_q;
  assign out_psum = acc_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: behavioural MAC on the lane interface, dot-product
// reference computed from the raw pair stream.

module tb_mac_operand_feeder;
  logic        clk = 0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        in_valid, in_ready;
  logic [3:0]  in_a, in_b;
  logic [3:0]  mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3;
  logic [15:0] mac_c, mac_out;
  logic        out_valid, out_ready;
  logic [15:0] out_psum;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ra[$];
  int rb[$];

  always #5 clk = ~clk;

  mac_operand_feeder dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
    .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2), .mac_b3(mac_b3),
    .mac_c(mac_c), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  // Combinational MAC: c + sum(unsigned a * signed b), wrapped to 16 bits.
  function automatic logic [15:0] mac_fn(input logic [15:0] aa, input logic [15:0] bb,
                                         input logic [15:0] c);
    int s;
    logic signed [3:0] w;
    s = int'($signed(c));
    for (int i = 0; i < 4; i++) begin
      w = bb[i*4 +: 4];
      s += int'(aa[i*4 +: 4]) * int'(w);
    end
    return s[15:0];
  endfunction

  assign mac_out = mac_fn({mac_a3, mac_a2, mac_a1, mac_a0},
                          {mac_b3, mac_b2, mac_b1, mac_b0}, mac_c);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start = 1;
    len   = 8'(k);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic push(input int a, input int b);
    in_valid = 1;
    in_a     = 4'(a);
    in_b     = 4'(b);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("push_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  // bub: 0 back-to-back, 1 two-cycle gap before every other pair, 2 random gaps.
  task automatic run_job(input int k, input int bub, input int stall, input bit poke,
                         input string tag);
    int s;
    logic [15:0] exp, held;
    s = 0;
    foreach (ra[i]) s += ra[i] * rb[i];
    exp = s[15:0];
    do_start(k);
    foreach (ra[i]) begin
      if (bub == 1 && (i % 2) == 1) idle(2);
      else if (bub == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (poke && i == 2) begin
        start = 1;
        len   = 8'd1;
      end
      push(ra[i], rb[i]);
      start = 0;
    end
    in_valid = 0;
    @(negedge clk);
    chk({tag, "_acc_outvalid"}, out_valid, 0);
    chk({tag, "_acc_inready"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_outvalid"}, out_valid, 1);
    chk({tag, "_psum"}, out_psum, exp);
    chk({tag, "_macc"}, mac_c, exp);
    held = out_psum;
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_psum"}, out_psum, held);
    end
    out_ready = 1;
    if (poke) begin
      start = 1;
      len   = 8'd1;
    end
    @(posedge clk); #1;
    out_ready = 0;
    start     = 0;
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_outvalid_after"}, out_valid, 0);
  endtask

  task automatic load_single();
    ra = '{1, 2, 3, 4};
    rb = '{1, -1, 2, -2};
  endtask

  initial begin
    reset = 0; start = 0; len = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_inready", in_ready, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_psum", out_psum, 0);
    chk("rst_lanes", {mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3}, 0);
    chk("rst_macc", mac_c, 0);
    @(posedge clk); #1;
    reset = 1;

    // len = 0 start is dropped
    do_start(0);
    @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_inready", in_ready, 0);

    load_single();
    run_job(1, 0, 0, 0, "single");
    chk("single_const", out_psum, 16'hFFFD);

    ra = '{1, 2, 3, 4, 15, 15, 15, 15};
    rb = '{1, -1, 2, -2, -8, -8, -8, -8};
    run_job(2, 1, 5, 1, "two_grp");
    chk("two_grp_const", out_psum, 16'hFE1D);

    repeat (4) begin
      int k;
      k = $urandom_range(1, 5);
      ra.delete();
      rb.delete();
      for (int i = 0; i < 4 * k; i++) begin
        ra.push_back(int'($urandom_range(0, 15)));
        rb.push_back(int'($urandom_range(0, 15)) - 8);
      end
      run_job(k, 2, $urandom_range(0, 3), 0, "rand");
    end

    ra.delete();
    rb.delete();
    for (int i = 0; i < 4 * 255; i++) begin
      ra.push_back(15);
      rb.push_back(7);
    end
    run_job(255, 0, 0, 0, "wrap");
    chk("wrap_const", out_psum, 16'd41564);

    // asynchronous reset in the middle of a group
    do_start(1);
    push(1, 1);
    push(2, -1);
    in_valid = 0;
    #2 reset = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_inready", in_ready, 0);
    chk("midrst_outvalid", out_valid, 0);
    chk("midrst_psum", out_psum, 0);
    chk("midrst_lanes", {mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3}, 0);
    @(posedge clk); #1;
    reset = 1;
    load_single();
    run_job(1, 0, 2, 1, "post_rst");
    chk("post_rst_const", out_psum, 16'hFFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
